// File: rtl/rv_branch_pred.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rv_branch_pred
// Purpose  : Direct-mapped BTB with 2-bit counters, mispredict flush, stats.
// Revision : 1.0 - initial release
// ============================================================================
module rv_branch_pred #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int ENTRIES          = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [IADDR_SPACE_BITS-1:0] i_fetch_pc,
  output logic                        o_pred_taken,
  output logic [IADDR_SPACE_BITS-1:0] o_pred_next,
  input  logic                        i_upd_valid,
  input  logic                        i_upd_is_branch,
  input  logic                        i_upd_is_jal,
  input  logic                        i_upd_taken,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_pc,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_target,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_pc_next,
  input  logic                        i_upd_pred,
  output logic                        o_flush,
  output logic [IADDR_SPACE_BITS-1:0] o_redirect_pc,
  output logic [31:0]                 o_stat_ctrl,
  output logic [31:0]                 o_stat_mispred
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = IADDR_SPACE_BITS - IDX - 2;
  localparam logic [IADDR_SPACE_BITS-1:0] PC_STEP = IADDR_SPACE_BITS'(4);

  logic                        r_valid  [ENTRIES];
  logic [TAG-1:0]              r_tag    [ENTRIES];
  logic [IADDR_SPACE_BITS-1:0] r_target [ENTRIES];
  logic [1:0]                  r_ctr    [ENTRIES];

  logic                        r_flush;
  logic [IADDR_SPACE_BITS-1:0] r_redirect;
  logic [31:0]                 r_stat_ctrl;
  logic [31:0]                 r_stat_mispred;

  // Low PC bits are always zero for aligned fetch; the carried prediction
  // bit is not needed because detection compares full next-PC values.
  logic w_unused;
  assign w_unused = ^{i_fetch_pc[1:0], i_upd_pc[1:0], i_upd_pred};

  logic [IDX-1:0] w_fidx;
  logic           w_fhit;
  assign w_fidx       = i_fetch_pc[IDX+1:2];
  assign w_fhit       = r_valid[w_fidx] && (r_tag[w_fidx] == i_fetch_pc[IADDR_SPACE_BITS-1:IDX+2]);
  assign o_pred_taken = w_fhit & r_ctr[w_fidx][1];
  assign o_pred_next  = o_pred_taken ? r_target[w_fidx] : i_fetch_pc + PC_STEP;

  logic [IDX-1:0]              w_uidx;
  logic [TAG-1:0]              w_utag;
  logic                        w_uhit;
  logic                        w_is_ctrl;
  logic                        w_act_taken;
  logic [IADDR_SPACE_BITS-1:0] w_act_next;
  logic                        w_mispred;
  logic [1:0]                  w_ctr_cur;
  logic [1:0]                  w_ctr_inc;
  logic [1:0]                  w_ctr_dec;
  logic                        w_wr_jump;
  logic                        w_wr_alloc;
  logic                        w_wr_train;
  logic                        w_wr_inval;
  logic                        w_wr_tgt;

  assign w_uidx      = i_upd_pc[IDX+1:2];
  assign w_utag      = i_upd_pc[IADDR_SPACE_BITS-1:IDX+2];
  assign w_uhit      = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_is_ctrl   = i_upd_is_branch | i_upd_is_jal;
  assign w_act_taken = i_upd_is_jal | (i_upd_is_branch & i_upd_taken);
  assign w_act_next  = w_act_taken ? i_upd_target : i_upd_pc + PC_STEP;
  assign w_mispred   = i_upd_valid && (w_act_next != i_upd_pc_next);

  assign w_ctr_cur = r_ctr[w_uidx];
  assign w_ctr_inc = (&w_ctr_cur) ? w_ctr_cur : w_ctr_cur + 2'd1;
  assign w_ctr_dec = (|w_ctr_cur) ? w_ctr_cur - 2'd1 : w_ctr_cur;

  // Jumps take priority should both type flags ever be set together.
  assign w_wr_jump  = i_upd_valid & i_upd_is_jal;
  assign w_wr_alloc = i_upd_valid & ~i_upd_is_jal & i_upd_is_branch & ~w_uhit & i_upd_taken;
  assign w_wr_train = i_upd_valid & ~i_upd_is_jal & i_upd_is_branch & w_uhit;
  assign w_wr_inval = i_upd_valid & ~w_is_ctrl & w_uhit;
  assign w_wr_tgt   = w_wr_jump | w_wr_alloc | (w_wr_train & i_upd_taken);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_flush        <= 1'b0;
      r_redirect     <= '0;
      r_stat_ctrl    <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (w_wr_jump) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= 2'b11;
      end else if (w_wr_alloc) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= 2'b10;
      end else if (w_wr_train) begin
        r_ctr[w_uidx]   <= i_upd_taken ? w_ctr_inc : w_ctr_dec;
      end else if (w_wr_inval) begin
        r_valid[w_uidx] <= 1'b0;
      end
      r_flush <= w_mispred;
      if (w_mispred) r_redirect <= w_act_next;
      if (i_upd_valid && w_is_ctrl) r_stat_ctrl <= r_stat_ctrl + 32'd1;
      if (w_mispred) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  // Tag/target are payload only; a write landing during reset is harmless
  // because the matching valid bit is cleared.
  always_ff @(posedge i_clk) begin
    if (w_wr_tgt) r_target[w_uidx] <= i_upd_target;
    if (w_wr_jump || w_wr_alloc) r_tag[w_uidx] <= w_utag;
  end

  assign o_flush        = r_flush;
  assign o_redirect_pc  = r_redirect;
  assign o_stat_ctrl    = r_stat_ctrl;
  assign o_stat_mispred = r_stat_mispred;

endmodule
`default_nettype wire

// File: tb/tb_rv_branch_pred.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rv_branch_pred
// Purpose  : Directed + randomized self-checking bench for rv_branch_pred.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_branch_pred;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_next;
  logic        upd_valid, upd_br, upd_jal, upd_taken, upd_pred;
  logic [31:0] upd_pc, upd_tgt, upd_pc_next;
  logic        flush;
  logic [31:0] redirect, stat_ctrl, stat_mis;

  always #5 clk = ~clk;

  rv_branch_pred #(.IADDR_SPACE_BITS(32), .ENTRIES(N)) dut (
    .i_clk(clk), .i_reset(rst), .i_fetch_pc(fetch_pc),
    .o_pred_taken(pred_taken), .o_pred_next(pred_next),
    .i_upd_valid(upd_valid), .i_upd_is_branch(upd_br), .i_upd_is_jal(upd_jal),
    .i_upd_taken(upd_taken), .i_upd_pc(upd_pc), .i_upd_target(upd_tgt),
    .i_upd_pc_next(upd_pc_next), .i_upd_pred(upd_pred),
    .o_flush(flush), .o_redirect_pc(redirect),
    .o_stat_ctrl(stat_ctrl), .o_stat_mispred(stat_mis)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Reference model: table of occupants kept as plain arrays
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_flush;
  logic [31:0] m_redirect, m_ctrl, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_flush    = 1'b0;
    m_redirect = '0;
    m_ctrl     = '0;
    m_mis      = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit          act_tk;
      logic [31:0] act_nx;
      int          i;
      act_tk  = upd_jal || (upd_br && upd_taken);
      act_nx  = act_tk ? upd_tgt : upd_pc + 32'd4;
      i       = m_idx(upd_pc);
      m_flush = upd_valid && (act_nx != upd_pc_next);
      if (upd_valid) begin
        if (m_flush) begin
          m_redirect = act_nx;
          m_mis      = m_mis + 32'd1;
        end
        if (upd_br || upd_jal) m_ctrl = m_ctrl + 32'd1;
        if (upd_jal) begin
          m_valid[i] = 1'b1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_tgt; m_ctr[i] = 3;
        end else if (upd_br) begin
          if (m_hit(upd_pc)) begin
            m_ctr[i] = upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                 : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (upd_taken) m_tgt[i] = upd_tgt;
          end else if (upd_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_tgt; m_ctr[i] = 2;
          end
        end else if (m_hit(upd_pc)) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("pred_taken", 32'(pred_taken), 32'(m_taken(fetch_pc)));
      chk("pred_next",  pred_next,       m_next(fetch_pc));
      chk("flush",      32'(flush),      32'(m_flush));
      chk("redirect",   redirect,        m_redirect);
      chk("stat_ctrl",  stat_ctrl,       m_ctrl);
      chk("stat_mis",   stat_mis,        m_mis);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input bit br, input bit jal, input bit tk,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] nx);
    upd_valid = 1'b1; upd_br = br; upd_jal = jal; upd_taken = tk;
    upd_pc = pc; upd_tgt = tgt; upd_pc_next = nx; upd_pred = tk;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit tk, input logic [31:0] nx);
    fetch_pc = pc;
    #1;
    chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({name, "_next"},  pred_next, nx);
  endtask

  logic [31:0] pool_hi;

  initial begin
    rst = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_br = 1'b0; upd_jal = 1'b0;
    upd_taken = 1'b0; upd_pred = 1'b0; upd_pc = '0; upd_tgt = '0; upd_pc_next = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // Reset state and first allocation
    look("rst_0x100", 32'h100, 1'b0, 32'h104);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_ctrl", stat_ctrl, 32'h0);
    upd(1, 0, 1, 32'h100, 32'h80, 32'h104);
    chk("alloc_flush", 32'(flush), 32'h1);
    chk("alloc_redirect", redirect, 32'h80);
    chk("alloc_mis", stat_mis, 32'h1);
    look("alloc_hit", 32'h100, 1'b1, 32'h80);

    // Counter hysteresis: two not-taken needed to flip from strong taken
    repeat (3) upd(1, 0, 1, 32'h100, 32'h80, 32'h80);
    chk("train_noflush", 32'(flush), 32'h0);
    upd(1, 0, 0, 32'h100, 32'h80, 32'h80);
    chk("nt1_flush", 32'(flush), 32'h1);
    chk("nt1_redirect", redirect, 32'h104);
    look("nt1", 32'h100, 1'b1, 32'h80);
    upd(1, 0, 0, 32'h100, 32'h80, 32'h80);
    look("nt2", 32'h100, 1'b0, 32'h104);
    chk("nt2_mis", stat_mis, 32'h3);
    chk("nt2_ctrl", stat_ctrl, 32'h6);

    // Jump install then invalidation by a non-control instruction
    pulse_reset();
    upd(0, 1, 0, 32'h200, 32'h40, 32'h204);
    look("jal", 32'h200, 1'b1, 32'h40);
    upd(0, 0, 0, 32'h200, 32'h0, 32'h40);
    chk("inval_flush", 32'(flush), 32'h1);
    chk("inval_redirect", redirect, 32'h204);
    chk("inval_ctrl", stat_ctrl, 32'h1);
    look("inval", 32'h200, 1'b0, 32'h204);

    // Aliasing plus back-to-back mispredicts
    pulse_reset();
    upd_valid = 1'b1; upd_br = 1'b1; upd_jal = 1'b0; upd_taken = 1'b1;
    upd_pc = 32'h100; upd_tgt = 32'h80; upd_pc_next = 32'h104;
    tick();
    chk("b2b1_flush", 32'(flush), 32'h1);
    chk("b2b1_redirect", redirect, 32'h80);
    upd_pc = 32'h140; upd_tgt = 32'h90; upd_pc_next = 32'h144;
    tick();
    upd_valid = 1'b0;
    chk("b2b2_flush", 32'(flush), 32'h1);
    chk("b2b2_redirect", redirect, 32'h90);
    look("alias_evicted", 32'h100, 1'b0, 32'h104);
    look("alias_owner", 32'h140, 1'b1, 32'h90);
    tick();
    chk("idle_flush", 32'(flush), 32'h0);

    // Address wrap and reset during an update
    pulse_reset();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    upd(1, 0, 1, 32'h100, 32'h80, 32'h104);
    tick();
    upd_valid = 1'b1; upd_br = 1'b0; upd_jal = 1'b1; upd_taken = 1'b0;
    upd_pc = 32'h100; upd_tgt = 32'h300; upd_pc_next = 32'h104;
    pulse_reset();
    chk("rstupd_flush", 32'(flush), 32'h0);
    chk("rstupd_redirect", redirect, 32'h0);
    chk("rstupd_ctrl", stat_ctrl, 32'h0);
    chk("rstupd_mis", stat_mis, 32'h0);
    look("rstupd", 32'h100, 1'b0, 32'h104);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int sel;
      pool_hi   = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'h0000_1000;
      upd_pc    = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                                               : pool_hi + 32'($urandom_range(0, 31)) * 32'd4;
      upd_valid = ($urandom_range(0, 3) != 0);
      sel       = int'($urandom_range(0, 3));
      upd_br    = (sel == 1) || (sel == 2);
      upd_jal   = (sel == 3);
      upd_taken = ($urandom_range(0, 1) != 0);
      upd_pred  = ($urandom_range(0, 1) != 0);
      upd_tgt   = $urandom & 32'hFFFF_FFFC;
      sel       = int'($urandom_range(0, 2));
      upd_pc_next = (sel == 0) ? m_next(upd_pc) :
                    (sel == 1) ? upd_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      fetch_pc  = ($urandom_range(0, 3) == 0) ? upd_pc
                : (($urandom_range(0, 1) != 0) ? 32'h0 : 32'h0000_1000) + 32'($urandom_range(0, 31)) * 32'd4;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else tick();
    end
    upd_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_branch_pred.md
RV_BRANCH_PRED -- requirements
Module: rv_branch_pred

Interface
REQ-001 SHALL have parameter IADDR_SPACE_BITS, default 32, instruction address width.
REQ-002 SHALL have parameter ENTRIES, default 16, BTB entry count (power of two, >=2); IDX=log2(ENTRIES), TAG=IADDR_SPACE_BITS-IDX-2.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port i_clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_fetch_pc  input  IADDR_SPACE_BITS  PC being fetched.
REQ-007 SHALL have port o_pred_taken  output  1  predicted taken for i_fetch_pc.
REQ-008 SHALL have port o_pred_next  output  IADDR_SPACE_BITS  predicted next PC.
REQ-009 SHALL have port i_upd_valid  input  1  resolved instruction present at ALU stage.
REQ-010 SHALL have ports i_upd_is_branch, i_upd_is_jal  input  1 each  conditional branch / unconditional jump (jal, jalr, mret).
REQ-011 SHALL have port i_upd_taken  input  1  branch condition resolved true.
REQ-012 SHALL have ports i_upd_pc, i_upd_target, i_upd_pc_next  input  IADDR_SPACE_BITS each  instruction PC, resolved target, next PC predicted at fetch.
REQ-013 SHALL have port i_upd_pred  input  1  prediction bit carried down the pipeline.
REQ-014 SHALL have ports o_flush  output  1  and o_redirect_pc  output  IADDR_SPACE_BITS  registered mispredict redirect.
REQ-015 SHALL have ports o_stat_ctrl, o_stat_mispred  output  32 each  control-instruction and mispredict counts.

Function
REQ-016 Entry SHALL hold valid, tag[TAG], target[IADDR_SPACE_BITS], ctr[2]; index=pc[IDX+1:2], tag=pc[IADDR_SPACE_BITS-1:IDX+2].
REQ-017 Lookup SHALL be combinational from stored state: hit=valid & tag match; o_pred_taken=hit & ctr[1].
REQ-018 o_pred_next SHALL be entry target when o_pred_taken, else i_fetch_pc+4 modulo 2^IADDR_SPACE_BITS (wraps to 0).
REQ-019 Update SHALL occur on rising edge when i_upd_valid; actual_taken=i_upd_is_jal | (i_upd_is_branch & i_upd_taken).
REQ-020 actual_next SHALL be i_upd_target when actual_taken, else i_upd_pc+4 (modulo wrap).
REQ-021 Branch hit: ctr SHALL saturating-increment (max 11) if taken, saturating-decrement (min 00) if not; target written only if taken.
REQ-022 Branch miss and taken: SHALL allocate (valid=1, tag, target, ctr=10), evicting any occupant; miss not taken: no write.
REQ-023 Jump (is_jal), hit or miss: SHALL write valid=1, tag, target, ctr=11.
REQ-024 Non-control (neither is_branch nor is_jal) with hit: entry SHALL be invalidated (valid=0); otherwise no write.
REQ-025 Mispredict SHALL be i_upd_valid & (actual_next != i_upd_pc_next); i_upd_pred SHALL NOT affect detection, only no-op compare.
REQ-026 o_flush SHALL be the registered mispredict (1-cycle latency, one-cycle pulse per mispredicted update); o_redirect_pc SHALL load actual_next only when mispredict, else hold.
REQ-027 Back-to-back mispredicts SHALL give o_flush high on consecutive cycles with each corresponding redirect PC.
REQ-028 Same-cycle lookup and update to same index: lookup SHALL return pre-update contents; new contents visible next cycle.
REQ-029 o_stat_ctrl SHALL increment on each valid update with is_branch|is_jal; o_stat_mispred on each mispredict; both wrap 0xFFFFFFFF->0.
REQ-030 Updates with i_upd_valid=0 SHALL change no state; o_flush SHALL go 0.

Reset
REQ-031 i_reset SHALL asynchronously clear all valid bits, set all ctr=01, clear o_flush, o_redirect_pc, both stat counters; target/tag need no reset.
REQ-032 Reset asserted mid-update SHALL take precedence; no entry written that edge; first post-reset lookup misses.

Verification
REQ-033 After reset, i_fetch_pc=0x100 -> o_pred_taken=0, o_pred_next=0x104.
REQ-034 Branch pc=0x100 taken, target 0x80, pc_next=0x104 -> next cycle o_flush=1, o_redirect_pc=0x80, stat_mispred=1; fetch 0x100 then predicts taken, next=0x80.
REQ-035 Same branch 3x taken then 1x not taken -> ctr 10->11->11->10, still predicts taken; second not-taken -> ctr 01, predicts 0x104.
REQ-036 Jal pc=0x200 target 0x40 installed, then non-control update pc=0x200 -> entry invalidated, o_flush=1, redirect 0x204.
REQ-037 Aliasing: branch 0x100 and 0x140 (ENTRIES=16) both taken -> 0x140 evicts 0x100; fetch 0x100 misses.
REQ-038 Fetch pc=0xFFFFFFFC miss -> o_pred_next=0x0; reset pulsed during update -> all outputs zero, table empty.
